// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator
//   Accumulates TAPS signed 16-bit tap products into a signed 32-bit frame sum
//   using one time-multiplexed 16-bit Brent-Kung prefix adder. Each sample takes
//   two adder passes: low half first, then high half with the stored carry and
//   the sign-extended operand. The finished sum is offered on a valid/ready port.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort (restores reset values)
//   in_data    signed tap product
//   in_valid   in_data valid
//   in_ready   sample accepted this cycle when in_valid is also high
//   out_data   registered frame sum
//   out_valid  out_data valid
//   out_ready  downstream consumes out_data
//   busy       high unless idle with no partial frame
module fir_tap_accumulator #(
  parameter int TAPS  = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {S_WAIT, S_LO, S_HI, S_OUT} state_t;

  state_t             state, state_nx;
  logic [31:0]        acc, acc_nx;
  logic [15:0]        op, op_nx;
  logic               carry_q, carry_nx;
  logic [CNT_W-1:0]   count, count_nx;

  logic [15:0]        add_1, add_2, sum;
  logic               c_in, c_out;
  logic [15:0]        g_bit, p_bit, g_grp, p_grp;

  // Adder operand mux; idle states present zero operands.
  always_comb begin
    add_1 = '0;
    add_2 = '0;
    c_in  = 1'b0;
    case (state)
      S_LO: begin
        add_1 = acc[15:0];
        add_2 = op;
      end
      S_HI: begin
        add_1 = acc[31:16];
        add_2 = {16{op[15]}};
        c_in  = carry_q;
      end
      default: ;
    endcase
  end

  // Brent-Kung prefix adder. Carry-in is folded into bit 0's generate so the
  // group generate at bit i is the carry out of bit i.
  always_comb begin
    p_bit    = add_1 ^ add_2;
    g_bit    = add_1 & add_2;
    g_grp    = g_bit;
    p_grp    = p_bit;
    g_grp[0] = g_bit[0] | (p_bit[0] & c_in);
    // Up-sweep: completes prefixes at positions 2^k-1.
    for (int unsigned d = 1; d < 16; d = d * 2) begin
      for (int unsigned i = 2 * d - 1; i < 16; i = i + 2 * d) begin
        g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i-d]);
        p_grp[i] = p_grp[i] & p_grp[i-d];
      end
    end
    // Down-sweep: fills in the remaining positions.
    for (int unsigned d = 4; d >= 1; d = d / 2) begin
      for (int unsigned i = 3 * d - 1; i < 16; i = i + 2 * d) begin
        g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i-d]);
        p_grp[i] = p_grp[i] & p_grp[i-d];
      end
    end
    sum   = p_bit ^ {g_grp[14:0], c_in};
    c_out = g_grp[15];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    op_nx    = op;
    carry_nx = carry_q;
    count_nx = count;
    case (state)
      S_WAIT: begin
        if (in_valid) begin
          op_nx    = in_data;
          state_nx = S_LO;
        end
      end
      S_LO: begin
        acc_nx[15:0] = sum;
        carry_nx     = c_out;
        state_nx     = S_HI;
      end
      S_HI: begin
        acc_nx[31:16] = sum;
        if (count == CNT_W'(TAPS - 1)) begin
          count_nx = '0;
          state_nx = S_OUT;
        end else begin
          count_nx = count + 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_nx   = '0;
          carry_nx = 1'b0;
          state_nx = S_WAIT;
        end
      end
      default: state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_WAIT;
      acc     <= '0;
      op      <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else if (clr) begin
      state   <= S_WAIT;
      acc     <= '0;
      op      <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      op      <= op_nx;
      carry_q <= carry_nx;
      count   <= count_nx;
    end
  end

  assign in_ready  = (state == S_WAIT);
  assign out_valid = (state == S_OUT);
  assign out_data  = acc;
  assign busy      = !((state == S_WAIT) && (count == '0));

endmodule

// File: tb/tb_fir_tap_accumulator.sv
module tb_fir_tap_accumulator;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_acc;
  int unsigned model_cnt;

  always #5 clk = ~clk;

  fir_tap_accumulator #(.TAPS(TAPS), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    model_acc = '0;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_add(input logic [15:0] d);
    model_acc = model_acc + {{16{d[15]}}, d};
    model_cnt++;
    if (model_cnt == TAPS) begin
      exp_q.push_back(model_acc);
      model_acc = '0;
      model_cnt = 0;
    end
  endtask

  // Offers one sample, waits (bounded) for in_ready, returns 1 after the accept edge.
  task automatic send(input logic [15:0] d);
    int unsigned n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    model_add(d);
  endtask

  task automatic wait_out();
    int unsigned n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: every handshake on the output is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        chk("sb_pending", 32'(exp_q.size()), 32'd1);
      else
        chk("sb_out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Frame 1: 1,2,3,4 back-to-back; in_ready pattern and output timing.
    for (int k = 0; k < TAPS; k++) begin
      chk("t1_rdy_wait", 32'(in_ready), 32'd1);
      send(16'(k + 1));
      chk("t1_rdy_lo",  32'(in_ready),  32'd0);
      chk("t1_busy_lo", 32'(busy),      32'd1);
      chk("t1_ov_lo",   32'(out_valid), 32'd0);
      tick();
      chk("t1_rdy_hi",  32'(in_ready),  32'd0);
      chk("t1_ov_hi",   32'(out_valid), 32'd0);
      tick();
    end
    chk("t1_ov_rise", 32'(out_valid), 32'd1);
    chk("t1_sum",     out_data,       32'h0000000A);
    tick();
    chk("t1_ov_fall", 32'(out_valid), 32'd0);
    chk("t1_rdy_back", 32'(in_ready), 32'd1);

    // Sign extension through the high pass.
    repeat (TAPS) send(16'hFFFF);
    wait_out();
    chk("t2_sum", out_data, 32'hFFFFFFFC);
    tick();

    // Low-half carry into the high half, then most-negative inputs.
    repeat (TAPS) send(16'h7FFF);
    wait_out();
    chk("t3_sum_pos", out_data, 32'h0001FFFC);
    tick();
    repeat (TAPS) send(16'h8000);
    wait_out();
    chk("t3_sum_neg", out_data, 32'hFFFE0000);
    tick();

    // Backpressure: output held, new input refused.
    out_ready = 1'b0;
    send(16'h0100); send(16'h0200); send(16'hFFFE); send(16'h0003);
    wait_out();
    in_data  = 16'h0055;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_ov",   32'(out_valid), 32'd1);
      chk("t4_hold_data", out_data,       32'h00000301);
      chk("t4_hold_rdy",  32'(in_ready),  32'd0);
      tick();
    end
    chk("t4_still_ov", 32'(out_valid), 32'd1);
    in_data   = 16'h0007;
    out_ready = 1'b1;
    tick();
    chk("t4_ov_drop",  32'(out_valid), 32'd0);
    chk("t4_no_same",  32'(in_ready),  32'd1);
    chk("t4_idle",     32'(busy),      32'd0);
    tick();
    chk("t4_accepted", 32'(in_ready),  32'd0);
    in_valid = 1'b0;
    model_add(16'h0007);
    repeat (TAPS - 1) send(16'h0001);
    wait_out();
    chk("t4_fresh_sum", out_data, 32'h0000000A);
    tick();

    // clr in S_HI part-way through a frame, then with in_valid in S_WAIT.
    send(16'h0005);
    send(16'h0005);
    tick();
    chk("t5_busy_hi", 32'(busy), 32'd1);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0009;
    tick();
    chk("t5_clr_rdy",  32'(in_ready),  32'd1);
    chk("t5_clr_busy", 32'(busy),      32'd0);
    chk("t5_clr_ov",   32'(out_valid), 32'd0);
    chk("t5_clr_acc",  out_data,       32'd0);
    tick();
    chk("t5_clr_block", 32'(in_ready), 32'd1);
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    repeat (TAPS) send(16'h0001);
    wait_out();
    chk("t5_sum", out_data, 32'h00000004);
    tick();

    // Asynchronous reset mid-frame.
    send(16'h0002);
    send(16'h0002);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy",  32'(in_ready),  32'd1);
    chk("t6_rst_busy", 32'(busy),      32'd0);
    chk("t6_rst_ov",   32'(out_valid), 32'd0);
    chk("t6_rst_acc",  out_data,       32'd0);
    #2 rst_n = 1'b1;
    model_clear();
    tick();
    repeat (TAPS) send(16'h0002);
    wait_out();
    chk("t6_sum", out_data, 32'h00000008);
    tick();

    repeat (2) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_accumulator.md
Name: fir_tap_accumulator

Overview:
- Sequential accumulator placed directly upstream of the 16-bit Brent-Kung prefix adder slice. It owns and drives that slice's operand, carry-in and sum/carry-out signals, and time-multiplexes one adder instance.
- Sums TAPS signed 16-bit FIR tap products into a 32-bit accumulator. Each sample takes two adder passes: low half, then high half with the stored carry.
- The final sum is presented to the FIR output stage over a valid/ready handshake.

Parameters:
- TAPS, 8, number of samples accumulated per output frame; legal range 2..256.
- CNT_W, 8, sample-counter width; must satisfy 2^CNT_W >= TAPS.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous frame abort; highest priority after rst_n.
- in_data  input  16  signed two's-complement tap product.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  32  signed accumulated frame sum.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes out_data.
- busy  output  1  high in any state except S_WAIT with count==0.

Behaviour:
- Reset (rst_n=0, async): state=S_WAIT, acc=0, op=0, carry_q=0, count=0, out_valid=0, in_ready=1, out_data=0, busy=0.
- FSM states: S_WAIT, S_LO, S_HI, S_OUT.
- S_WAIT:
  - in_ready=1.
  - On in_valid&in_ready: op<=in_data, go to S_LO.
  - Otherwise hold.
- S_LO:
  - in_ready=0.
  - Adder inputs: add_1=acc[15:0], add_2=op, c_in=0.
  - acc[15:0]<=sum, carry_q<=c_out, go to S_HI.
- S_HI:
  - in_ready=0.
  - Adder inputs: add_1=acc[31:16], add_2={16{op[15]}} (sign extension), c_in=carry_q.
  - acc[31:16]<=sum.
  - If count==TAPS-1: count<=0, go to S_OUT. Else count<=count+1, go to S_WAIT.
- S_OUT:
  - out_valid=1, out_data=acc, in_ready=0.
  - On out_ready: acc<=0, carry_q<=0, go to S_WAIT.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Each sample occupies 3 cycles (accept, S_LO, S_HI); peak input rate is one sample per 3 cycles.
  - out_valid rises 2 clock edges after the edge that accepts the final sample of the frame.
- Adder usage: the adder is combinational. Its inputs are muxed from state; in S_WAIT/S_OUT they are driven to 0.
- Arithmetic: result is modulo 2^32. With TAPS<=256 the maximum magnitude is 2^23, so no overflow is possible and no flag is provided.
- out_data is acc registered, not the combinational adder output.
- clr=1: same register values as reset on the next edge, in any state.
  - An in-flight sample is discarded.
  - out_valid drops even if out_ready=0.
  - A simultaneous in_valid is not accepted.
- in_valid while in_ready=0: ignored; upstream must hold data (standard valid/ready).
- out_valid&out_ready in S_OUT: the next sample can be accepted on the following cycle, not the same cycle.
- Reset asserted mid-frame: immediate return to reset values, independent of clk.

Test Plan:
- TAPS=4, inputs 1,2,3,4 back-to-back, out_ready=1 -> out_data=0x0000000A; out_valid high exactly 2 edges after the 4th accept, for 1 cycle; in_ready pattern 1,0,0 repeating.
- TAPS=4, input 0xFFFF x4 -> out_data=0xFFFFFFFC (sign extension through the high pass).
- TAPS=4, input 0x7FFF x4 -> out_data=0x0001FFFC (low-half carry into high half); then 0x8000 x4 -> 0xFFFE0000.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, a new in_valid is not accepted; out_ready=1 -> next frame starts from acc=0.
- clr pulsed in S_HI after 2 of 4 samples of value 5, then 4 samples of value 1 -> out_data=0x00000004.
- rst_n low mid-frame, asynchronous to clk -> outputs reach reset values before the next edge; a fresh 4-sample frame sums correctly.
